// File: rtl/pcie_byte_pkg.sv
// Shared definitions for the byte-level serial link: the COM alignment symbol
// and the receiver state encoding.
package pcie_byte_pkg;

    localparam logic [7:0] COM = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        SYNC   = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rx_shift_window.sv
// Serial shift window: presents the last 8 received bits (newest in bit 0)
// combinationally, together with a COM-match flag.
module rx_shift_window
    import pcie_byte_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       serial_in,
    output logic [7:0] win,
    output logic       is_com
);

    // Bit 7 of the window is always shifted out on the next edge, so only the
    // lower seven bits need storage.
    logic [6:0] sr_reg;

    assign win    = {sr_reg, serial_in};
    assign is_com = (win == COM);

    always_ff @(posedge clk) begin
        if (srst) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= win[6:0];
        end
    end

endmodule

// File: rtl/byte_rx_serial.sv
// Serial-in byte receiver: aligns to COM symbols, then emits one byte per
// eight bit clocks with a payload/idle flag; drops lock after MAX_RUN data bytes.
module byte_rx_serial
    import pcie_byte_pkg::*;
#(
    parameter int COM_LOCK = 4,
    parameter int MAX_RUN  = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       serial_in,
    output logic [7:0] DATA_OUT,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       locked,
    output logic       lock_err
);

    localparam int CW = $clog2(COM_LOCK + 1);
    localparam int RW = $clog2(MAX_RUN + 1);

    logic [7:0] win;
    logic       is_com;

    rx_shift_window u_win (
        .clk       (CLK),
        .srst      (RESET),
        .serial_in (serial_in),
        .win       (win),
        .is_com    (is_com)
    );

    rx_state_t state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0] com_cnt_reg, com_cnt_next;
    logic [RW-1:0] run_cnt_reg, run_cnt_next;
    logic          timeout;

    logic [7:0] data_reg, data_next;
    logic       valid_reg, valid_next;
    logic       stb_reg, stb_next;
    logic       locked_reg, locked_next;
    logic       err_reg, err_next;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        com_cnt_next = com_cnt_reg;
        run_cnt_next = run_cnt_reg;
        timeout      = 1'b0;
        case (state_reg)
            SEARCH: begin
                if (is_com) begin
                    bit_cnt_next = 3'd0;
                    com_cnt_next = CW'(1);
                    if (COM_LOCK == 1) begin
                        state_next   = SYNC;
                        run_cnt_next = '0;
                    end else begin
                        state_next = ALIGN;
                    end
                end
            end
            ALIGN: begin
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    if (!is_com) begin
                        // The failing window is not re-examined as a fresh COM.
                        state_next   = SEARCH;
                        com_cnt_next = '0;
                    end else if (com_cnt_reg == CW'(COM_LOCK - 1)) begin
                        state_next   = SYNC;
                        run_cnt_next = '0;
                    end else begin
                        com_cnt_next = com_cnt_reg + CW'(1);
                    end
                end
            end
            SYNC: begin
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    if (is_com) begin
                        run_cnt_next = '0;
                    end else begin
                        run_cnt_next = run_cnt_reg + RW'(1);
                        if (run_cnt_reg == RW'(MAX_RUN - 1)) begin
                            timeout      = 1'b1;
                            state_next   = SEARCH;
                            com_cnt_next = '0;
                        end
                    end
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    // Output logic: registered outputs change on the edge that completes a byte
    always_comb begin
        data_next   = data_reg;
        valid_next  = valid_reg;
        stb_next    = 1'b0;
        err_next    = 1'b0;
        locked_next = locked_reg;
        if (state_reg == SYNC && bit_cnt_reg == 3'd7) begin
            data_next  = win;
            valid_next = !is_com;
            stb_next   = 1'b1;
        end
        if (timeout) begin
            err_next    = 1'b1;
            locked_next = 1'b0;
        end else if (state_next == SYNC && state_reg != SYNC) begin
            locked_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt_reg <= '0;
            com_cnt_reg <= '0;
            run_cnt_reg <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            stb_reg     <= 1'b0;
            locked_reg  <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            bit_cnt_reg <= bit_cnt_next;
            com_cnt_reg <= com_cnt_next;
            run_cnt_reg <= run_cnt_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            stb_reg     <= stb_next;
            locked_reg  <= locked_next;
            err_reg     <= err_next;
        end
    end

    assign DATA_OUT  = data_reg;
    assign valid_out = valid_reg;
    assign byte_stb  = stb_reg;
    assign locked    = locked_reg;
    assign lock_err  = err_reg;

endmodule

// File: tb/tb_byte_rx_serial.sv
// Bench for byte_rx_serial (COM_LOCK=4, MAX_RUN=4): bytes expected on the
// output are queued as they are driven and matched when byte_stb fires.
module tb_byte_rx_serial;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] DATA_OUT;
    logic       valid_out, byte_stb, locked, lock_err;

    byte_rx_serial #(.COM_LOCK(4), .MAX_RUN(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .serial_in (serial_in),
        .DATA_OUT  (DATA_OUT),
        .valid_out (valid_out),
        .byte_stb  (byte_stb),
        .locked    (locked),
        .lock_err  (lock_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       e;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle
    always @(negedge CLK) begin
        if (byte_stb === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_stb", {8'h00, DATA_OUT}, 16'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data", {8'h00, DATA_OUT}, {8'h00, e.d});
                check("valid", {15'd0, valid_out}, {15'd0, e.v});
                check("lock_err", {15'd0, lock_err}, {15'd0, e.e});
                check("locked_at_stb", {15'd0, locked}, {15'd0, e.l});
                $display("byte %h valid=%0b lock_err=%0b locked=%0b", DATA_OUT, valid_out, lock_err, locked);
            end
        end else if (lock_err !== 1'b0) begin
            check("lock_err_no_stb", {15'd0, lock_err}, 16'd0);
        end
    end

    // Drive one byte MSB-first; optionally expect it on the output.
    task automatic send_byte(input logic [7:0] b, input bit exp_stb, input bit exp_err,
                             input logic exp_lock, input string tag);
        if (exp_stb) begin
            exp_t e;
            e.d = b;
            e.v = (b != 8'hBC);
            e.e = exp_err;
            e.l = exp_lock;
            exp_q.push_back(e);
        end
        for (int i = 7; i >= 0; i--) begin
            serial_in = b[i];
            @(posedge CLK);
            #1;
        end
        check(tag, {15'd0, locked}, {15'd0, exp_lock});
    endtask

    task automatic reset_edge(input string tag);
        RESET = 1'b1;
        serial_in = 1'($urandom_range(0, 1));
        @(posedge CLK);
        #1;
        check(tag, {4'd0, DATA_OUT, valid_out, byte_stb, locked, lock_err}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with random input, then a COM-free stream
        for (int i = 0; i < 3; i++) reset_edge("reset_outs");
        RESET = 1'b0;
        send_byte(8'h00, 0, 0, 1'b0, "no_com_lock0");
        send_byte(8'h00, 0, 0, 1'b0, "no_com_lock1");

        // 2: three junk bits then four COMs
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'b0;
            @(posedge CLK);
            #1;
        end
        send_byte(8'hBC, 0, 0, 1'b0, "align_com1");
        send_byte(8'hBC, 0, 0, 1'b0, "align_com2");
        send_byte(8'hBC, 0, 0, 1'b0, "align_com3");
        send_byte(8'hBC, 0, 0, 1'b1, "align_com4");

        // 3/4: payload with interleaved COMs keeps the run counter below MAX_RUN
        send_byte(8'h25, 1, 0, 1'b1, "sync_25");
        send_byte(8'hBC, 1, 0, 1'b1, "sync_bc_a");
        send_byte(8'hF9, 1, 0, 1'b1, "sync_f9");
        send_byte(8'h4F, 1, 0, 1'b1, "sync_4f");
        send_byte(8'hA6, 1, 0, 1'b1, "sync_a6");
        send_byte(8'hBC, 1, 0, 1'b1, "sync_bc_b");
        send_byte(8'h39, 1, 0, 1'b1, "sync_39");
        send_byte(8'hA8, 1, 0, 1'b1, "sync_a8");
        send_byte(8'hBC, 1, 0, 1'b1, "sync_bc_c");

        // 6: four data bytes in a row -> timeout on the fourth
        send_byte(8'h11, 1, 0, 1'b1, "run_1");
        send_byte(8'h22, 1, 0, 1'b1, "run_2");
        send_byte(8'h33, 1, 0, 1'b1, "run_3");
        send_byte(8'h44, 1, 1, 1'b0, "run_4_drop");

        // 5: failed alignment, then a clean lock
        send_byte(8'hBC, 0, 0, 1'b0, "part_com1");
        send_byte(8'hBC, 0, 0, 1'b0, "part_com2");
        send_byte(8'hF9, 0, 0, 1'b0, "part_break");
        send_byte(8'hBC, 0, 0, 1'b0, "relock_com1");
        send_byte(8'hBC, 0, 0, 1'b0, "relock_com2");
        send_byte(8'hBC, 0, 0, 1'b0, "relock_com3");
        send_byte(8'hBC, 0, 0, 1'b1, "relock_com4");

        // 7: reset mid-byte while locked
        for (int i = 7; i >= 5; i--) begin
            serial_in = 1'b1;
            @(posedge CLK);
            #1;
        end
        reset_edge("midbyte_reset");
        RESET = 1'b0;
        send_byte(8'hBC, 0, 0, 1'b0, "post_rst_com1");
        send_byte(8'hBC, 0, 0, 1'b0, "post_rst_com2");
        send_byte(8'hBC, 0, 0, 1'b0, "post_rst_com3");
        send_byte(8'hBC, 0, 0, 1'b1, "post_rst_com4");
        send_byte(8'h77, 1, 0, 1'b1, "post_rst_data");

        @(posedge CLK);
        #1;
        check("sb_drain", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
